apb_multi_requester: RTL and testbench
======================================

# apb_multi_requester

Parametrised APB requester that turns single front-side transfer requests into compliant APB3 SETUP/ACCESS sequences toward `NUM_SLAVE` completers. It decodes the address to one `PSEL` line, supports wait states and per-slave `PSLVERR`, and returns one registered response pulse per request. It sits between a bus-master front end (CPU/DMA command port) and the APB completer fabric, replacing point-to-point wiring with a single decoded requester.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `NUM_SLAVE`, 4: number of completers, 1..16.
- `SLAVE_ADDR_BITS`, 12: each completer owns a 2^`SLAVE_ADDR_BITS`-byte window.
- `BASE_ADDR`, 32'h1000_0000: start of slave 0's window; windows are contiguous.
- `TIMEOUT_CYCLES`, 16: ACCESS-cycle limit, used only with `APB_TIMEOUT_EN`.

Ports:
- `PCLK` in 1: clock. One clock only.
- `PRESET` in 1: reset, asynchronous, active-low.
- `transfer` in 1: request strobe, sampled only when `busy`=0.
- `write` in 1: 1=write, 0=read.
- `addr` in `ADDR_WIDTH`: byte address.
- `wdata` in `DATA_WIDTH`: write data.
- `busy` out 1: request in flight. New requests are ignored while it is high.
- `ready` out 1: one-cycle response pulse.
- `rdata` out `DATA_WIDTH`: read data, valid with `ready`. It is 0 for writes and errors.
- `error` out 1: valid with `ready`. Set for decode error, `PSLVERR`, or timeout.
- `PADDR` out `ADDR_WIDTH`: APB address.
- `PSEL` out `NUM_SLAVE`: one-hot select.
- `PENABLE` out 1: APB enable.
- `PWRITE` out 1: APB direction.
- `PWDATA` out `DATA_WIDTH`: APB write data.
- `PREADY` in `NUM_SLAVE`: per-slave ready.
- `PRDATA` in `NUM_SLAVE*DATA_WIDTH`: per-slave read data. Slave i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `PSLVERR` in `NUM_SLAVE`: per-slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE + `transfer`=1:** capture `write`, `addr` and `wdata` into `PWRITE`, `PADDR` and `PWDATA`, then decode.
- **Decode:**
  - offset = `addr` − `BASE_ADDR` (unsigned, `ADDR_WIDTH` bits).
  - idx = offset >> `SLAVE_ADDR_BITS`.
  - Hit when `addr` ≥ `BASE_ADDR` and idx < `NUM_SLAVE`.
- **Hit:** go to SETUP with `PSEL[idx]`=1 and `PENABLE`=0.
- **Miss (decode error):** stay in IDLE, keep `PSEL` at 0, and pulse `ready`=1 / `error`=1 next cycle.
- **SETUP → ACCESS:** unconditional after one cycle. `PENABLE`=1.
- **ACCESS + `PREADY[idx]`=1 → IDLE:**
  - Drop `PSEL` and `PENABLE`.
  - Register the response: `ready`=1, `error`=`PSLVERR[idx]`, `rdata` = the `PRDATA` slice of idx when reading without error, else 0.
- **ACCESS + `PREADY[idx]`=0:** stay in ACCESS. `PADDR`, `PWRITE`, `PWDATA` and `PSEL` stay stable.
- **Ignored inputs:**
  - `PREADY`, `PSLVERR` and `PRDATA` from unselected slaves.
  - `PREADY` during SETUP.
  - Front inputs while `busy`.
- **`busy`:** high exactly when state ≠ IDLE.
- **Back-to-back:** a `transfer` in the same cycle as a `ready` pulse is accepted, because the state is IDLE.

## Timing
- **Reset:** all outputs 0, state IDLE.
- **Reset mid-operation:** asserting `PRESET` low immediately clears `PSEL`, `PENABLE` and `busy`. No `ready` pulse is issued for the aborted request.
- **Hit, zero wait states** (request accepted at edge n):
  - SETUP in cycle n+1.
  - ACCESS in cycle n+2.
  - `ready` in cycle n+3.
- **Wait states:** each cycle with `PREADY[idx]`=0 in ACCESS adds one cycle of latency.
- **Decode error:** `ready`/`error` in cycle n+1.
- **`ready`:** high for exactly one cycle per accepted request.
- **Minimum request spacing:** 3 cycles for hits, 1 cycle for decode errors.

## Configuration
- **`APB_TIMEOUT_EN` defined:**
  - A counter of width clog2(`TIMEOUT_CYCLES`+1) clears on entering ACCESS and increments each ACCESS cycle without `PREADY[idx]`.
  - When it reaches `TIMEOUT_CYCLES`, the transfer aborts: go to IDLE, drop `PSEL` and `PENABLE`, pulse `ready`=1, `error`=1, `rdata`=0.
  - If `PREADY` arrives in the same cycle the counter hits the limit, `PREADY` wins and the transfer completes normally.
- **Undefined:** no counter is present, and ACCESS waits indefinitely.

## Test plan
- Write 0x1000_2004 / 0xDEAD_BEEF, slave 2 zero-wait → `PSEL`=4'b0100 for 2 cycles, `PENABLE` in the 2nd, `PWDATA`=0xDEADBEEF, `ready` at n+3, `error`=0, `rdata`=0.
- Read 0x1000_1010, slave 1 holds `PREADY` low 3 cycles and returns 0x1234_5678 → `ready` at n+6, `rdata`=0x12345678, address/control stable throughout ACCESS.
- Read 0x1000_4000 (idx 4 ≥ `NUM_SLAVE`) and read 0x0FFF_FFFC → no `PSEL` activity, `ready`=1, `error`=1 at n+1.
- Slave 0 returns `PSLVERR`=1 with `PREADY` → `error`=1, `rdata`=0. A `transfer` held in the `ready` cycle starts SETUP on the next cycle.
- With `APB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, slave 3 never ready → abort after 16 ACCESS cycles with `error`=1. A second case with `PREADY` on the 16th cycle completes normally.
- Assert `PRESET` low during ACCESS → `PSEL`, `PENABLE` and `busy` go to 0 asynchronously, no `ready`. The next request after release behaves normally.

Source files
------------

// File: rtl/apb_multi_requester.sv
// APB3 requester: turns single front-side transfer requests into SETUP/ACCESS
// sequences towards NUM_SLAVE completers with contiguous address windows.
// Optional ACCESS timeout: define APB_TIMEOUT_EN to enable the watchdog.
//
// Front-side handshake: a request is taken on any clock edge where
// transfer=1 and busy=0; exactly one ready pulse (with error/rdata valid)
// follows for every request taken, and nothing on the front side is sampled
// while busy=1.
module apb_multi_requester #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    NUM_SLAVE       = 4,
    parameter int                    SLAVE_ADDR_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h1000_0000,
    parameter int                    TIMEOUT_CYCLES  = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic                            transfer,
    input  logic                            write,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    output logic                            busy,
    output logic                            ready,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            error,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic [NUM_SLAVE-1:0]            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    input  logic [NUM_SLAVE-1:0]            PREADY,
    input  logic [NUM_SLAVE*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVE-1:0]            PSLVERR
);

    localparam int IDX_W = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [NUM_SLAVE-1:0]    psel_d;
    logic                    penable_d, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_d, rdata_d;
    logic                    ready_d, error_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    // Address decode of the incoming request (only used while IDLE).
    logic [ADDR_WIDTH-1:0]   offset, slot;
    logic                    hit;
    logic [IDX_W-1:0]        dec_idx;

    assign offset  = addr - BASE_ADDR;
    assign slot    = offset >> SLAVE_ADDR_BITS;
    assign hit     = (addr >= BASE_ADDR) && (slot < ADDR_WIDTH'(NUM_SLAVE));
    assign dec_idx = slot[IDX_W-1:0];

    assign busy = (state != IDLE);

    // Pick the completion signals of the currently addressed slave only.
    logic                  sel_ready, sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output logic; response outputs default to idle.
    always_comb begin
        state_d   = state;
        idx_d     = idx_q;
        paddr_d   = PADDR;
        psel_d    = PSEL;
        penable_d = PENABLE;
        pwrite_d  = PWRITE;
        pwdata_d  = PWDATA;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        rdata_d   = '0;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state)
            IDLE: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwrite_d = write;
                    pwdata_d = wdata;
                    if (hit) begin
                        idx_d           = dec_idx;
                        psel_d          = '0;
                        psel_d[dec_idx] = 1'b1;
                        penable_d       = 1'b0;
                        state_d         = SETUP;
                    end else begin
                        // Decode miss: answer immediately, no bus activity.
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    error_d   = sel_err;
                    rdata_d   = (!PWRITE && !sel_err) ? sel_rdata : '0;
                    state_d   = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    // This is the last allowed wait cycle: abort the transfer.
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        psel_d    = '0;
                        penable_d = 1'b0;
                        ready_d   = 1'b1;
                        error_d   = 1'b1;
                        state_d   = IDLE;
                    end
                end
`endif
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered APB/response outputs; reset aborts everything.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state   <= IDLE;
            idx_q   <= '0;
            PADDR   <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            ready   <= 1'b0;
            error   <= 1'b0;
            rdata   <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state   <= state_d;
            idx_q   <= idx_d;
            PADDR   <= paddr_d;
            PSEL    <= psel_d;
            PENABLE <= penable_d;
            PWRITE  <= pwrite_d;
            PWDATA  <= pwdata_d;
            ready   <= ready_d;
            error   <= error_d;
            rdata   <= rdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_multi_requester.sv
// Directed bench for apb_multi_requester: zero-wait write, wait-state read,
// decode errors, PSLVERR with back-to-back request, reset mid-transfer and,
// when APB_TIMEOUT_EN is defined, the ACCESS timeout.
module tb_apb_multi_requester;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic             PCLK;
    logic             PRESET;
    logic             transfer;
    logic             write;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic             busy;
    logic             ready;
    logic [DW-1:0]    rdata;
    logic             error;
    logic [AW-1:0]    PADDR;
    logic [NS-1:0]    PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [DW-1:0]    PWDATA;
    logic [NS-1:0]    PREADY;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]    PSLVERR;

    int n_cmp = 0;
    int n_err = 0;

    apb_multi_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVE(NS),
        .SLAVE_ADDR_BITS(12), .BASE_ADDR(32'h1000_0000), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .busy(busy), .ready(ready), .rdata(rdata),
        .error(error), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR)
    );

    // Clock
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance one cycle; inputs are driven and outputs sampled at negedge.
    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic set_rdata(input int s, input logic [DW-1:0] v);
        PRDATA[s*DW +: DW] = v;
    endtask

    task automatic request(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        transfer = 1'b1;
        write    = wr;
        addr     = a;
        wdata    = d;
    endtask

    task automatic test_reset();
        PRESET = 1'b0; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        PREADY = '0; PRDATA = '0; PSLVERR = '0;
        #1;
        n_cmp++; if (PSEL !== 4'b0000) begin n_err++; $display("FAIL rst_psel: got %b want 0000", PSEL); end
        n_cmp++; if (PENABLE !== 1'b0) begin n_err++; $display("FAIL rst_penable: got %b want 0", PENABLE); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (ready !== 1'b0 || error !== 1'b0) begin n_err++; $display("FAIL rst_resp: got ready=%b error=%b want 0/0", ready, error); end
        n_cmp++; if (rdata !== 32'h0 || PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin
            n_err++; $display("FAIL rst_data: rdata=%h PADDR=%h PWDATA=%h PWRITE=%b want all 0", rdata, PADDR, PWDATA, PWRITE); end
        tick(); tick();
        PRESET = 1'b1;
        tick();
    endtask

    task automatic test_write_zero_wait();
        PREADY = 4'b0100;                 // slave 2 always ready (ignored in SETUP)
        request(1'b1, 32'h1000_2004, 32'hDEAD_BEEF);
        tick();                           // SETUP
        transfer = 1'b0;
        n_cmp++; if (PSEL !== 4'b0100 || PENABLE !== 1'b0) begin n_err++; $display("FAIL wr_setup: PSEL=%b PENABLE=%b want 0100/0", PSEL, PENABLE); end
        n_cmp++; if (PADDR !== 32'h1000_2004 || PWRITE !== 1'b1 || PWDATA !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL wr_setup_bus: PADDR=%h PWRITE=%b PWDATA=%h want 10002004/1/deadbeef", PADDR, PWRITE, PWDATA); end
        n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL wr_setup_busy: busy=%b ready=%b want 1/0", busy, ready); end
        tick();                           // ACCESS
        n_cmp++; if (PSEL !== 4'b0100 || PENABLE !== 1'b1 || ready !== 1'b0) begin
            n_err++; $display("FAIL wr_access: PSEL=%b PENABLE=%b ready=%b want 0100/1/0", PSEL, PENABLE, ready); end
        tick();                           // response
        n_cmp++; if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h0) begin
            n_err++; $display("FAIL wr_resp: ready=%b error=%b rdata=%h want 1/0/0", ready, error, rdata); end
        n_cmp++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL wr_release: PSEL=%b PENABLE=%b busy=%b want 0000/0/0", PSEL, PENABLE, busy); end
        tick();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_once: got %b want 0", ready); end
        PREADY = '0;
    endtask

    task automatic test_read_wait();
        // Unselected slaves are ready with junk data; only slave 1 counts.
        PREADY  = 4'b1101;
        PSLVERR = 4'b1101;
        set_rdata(0, 32'hAAAA_0000); set_rdata(1, 32'h1234_5678);
        set_rdata(2, 32'hAAAA_2222); set_rdata(3, 32'hAAAA_3333);
        request(1'b0, 32'h1000_1010, 32'h5555_5555);
        tick();                           // SETUP
        transfer = 1'b0;
        n_cmp++; if (PSEL !== 4'b0010 || PENABLE !== 1'b0) begin n_err++; $display("FAIL rd_setup: PSEL=%b PENABLE=%b want 0010/0", PSEL, PENABLE); end
        tick();                           // ACCESS 1
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (PSEL !== 4'b0010 || PENABLE !== 1'b1 || PADDR !== 32'h1000_1010 || PWRITE !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL rd_wait_%0d: PSEL=%b PENABLE=%b PADDR=%h PWRITE=%b ready=%b busy=%b want 0010/1/10001010/0/0/1",
                         i, PSEL, PENABLE, PADDR, PWRITE, ready, busy);
            end
            tick();
        end
        n_cmp++; if (PENABLE !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL rd_access4: PENABLE=%b ready=%b want 1/0", PENABLE, ready); end
        PREADY = 4'b1111;
        PSLVERR = 4'b1101;
        tick();
        n_cmp++; if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h1234_5678) begin
            n_err++; $display("FAIL rd_resp: ready=%b error=%b rdata=%h want 1/0/12345678", ready, error, rdata); end
        n_cmp++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin n_err++; $display("FAIL rd_release: PSEL=%b PENABLE=%b want 0000/0", PSEL, PENABLE); end
        PREADY = '0; PSLVERR = '0; PRDATA = '0;
        tick();
    endtask

    task automatic test_decode_error();
        request(1'b0, 32'h1000_4000, 32'h0);
        tick();
        n_cmp++; if (ready !== 1'b1 || error !== 1'b1 || rdata !== 32'h0) begin
            n_err++; $display("FAIL dec_hi: ready=%b error=%b rdata=%h want 1/1/0", ready, error, rdata); end
        n_cmp++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL dec_hi_bus: PSEL=%b PENABLE=%b busy=%b want 0000/0/0", PSEL, PENABLE, busy); end
        request(1'b0, 32'h0FFF_FFFC, 32'h0);   // next request one cycle later
        tick();
        transfer = 1'b0;
        n_cmp++; if (ready !== 1'b1 || error !== 1'b1 || PSEL !== 4'b0000) begin
            n_err++; $display("FAIL dec_lo: ready=%b error=%b PSEL=%b want 1/1/0000", ready, error, PSEL); end
        tick();
        n_cmp++; if (ready !== 1'b0 || error !== 1'b0) begin n_err++; $display("FAIL dec_idle: ready=%b error=%b want 0/0", ready, error); end
    endtask

    task automatic test_slverr_back_to_back();
        PREADY = 4'b0001; PSLVERR = 4'b0001;
        set_rdata(0, 32'h55AA_55AA);
        request(1'b0, 32'h1000_0000, 32'h0);
        tick();                           // SETUP
        n_cmp++; if (PSEL !== 4'b0001) begin n_err++; $display("FAIL err_setup: PSEL=%b want 0001", PSEL); end
        tick();                           // ACCESS, completes at next edge
        // New request held while busy: must not disturb the current one.
        request(1'b1, 32'h1000_3008, 32'h0BAD_F00D);
        n_cmp++; if (PADDR !== 32'h1000_0000 || PWRITE !== 1'b0) begin
            n_err++; $display("FAIL err_hold: PADDR=%h PWRITE=%b want 10000000/0", PADDR, PWRITE); end
        tick();                           // ready cycle, transfer still high
        n_cmp++; if (ready !== 1'b1 || error !== 1'b1 || rdata !== 32'h0) begin
            n_err++; $display("FAIL err_resp: ready=%b error=%b rdata=%h want 1/1/0", ready, error, rdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL err_idle: busy=%b want 0", busy); end
        PSLVERR = '0; PRDATA = '0;
        tick();                           // second request in SETUP
        transfer = 1'b0;
        PREADY = 4'b1000;
        n_cmp++; if (PSEL !== 4'b1000 || PENABLE !== 1'b0 || PADDR !== 32'h1000_3008 || PWDATA !== 32'h0BAD_F00D || busy !== 1'b1) begin
            n_err++; $display("FAIL b2b_setup: PSEL=%b PENABLE=%b PADDR=%h PWDATA=%h busy=%b want 1000/0/10003008/0badf00d/1",
                              PSEL, PENABLE, PADDR, PWDATA, busy); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_once: got %b want 0", ready); end
        tick();                           // ACCESS
        tick();
        n_cmp++; if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h0) begin
            n_err++; $display("FAIL b2b_resp: ready=%b error=%b rdata=%h want 1/0/0", ready, error, rdata); end
        PREADY = '0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        PREADY = 4'b0000;
        request(1'b0, 32'h1000_1000, 32'h0);
        tick();
        transfer = 1'b0;
        tick();                           // ACCESS, slave 1 stalls
        n_cmp++; if (PENABLE !== 1'b1 || PSEL !== 4'b0010) begin n_err++; $display("FAIL rm_access: PENABLE=%b PSEL=%b want 1/0010", PENABLE, PSEL); end
        #2 PRESET = 1'b0;
        #1;
        n_cmp++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rm_async: PSEL=%b PENABLE=%b busy=%b want 0000/0/0", PSEL, PENABLE, busy); end
        PREADY = 4'b0010;
        tick();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rm_no_ready: got %b want 0", ready); end
        PRESET = 1'b1;
        tick();
        n_cmp++; if (ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rm_after: ready=%b busy=%b want 0/0", ready, busy); end
        PREADY = 4'b1000;
        set_rdata(3, 32'hCAFE_0003);
        request(1'b0, 32'h1000_3ffc, 32'h0);
        tick();
        transfer = 1'b0;
        n_cmp++; if (PSEL !== 4'b1000 || PENABLE !== 1'b0) begin n_err++; $display("FAIL rm_next_setup: PSEL=%b PENABLE=%b want 1000/0", PSEL, PENABLE); end
        tick();
        tick();
        n_cmp++; if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'hCAFE_0003) begin
            n_err++; $display("FAIL rm_next_resp: ready=%b error=%b rdata=%h want 1/0/cafe0003", ready, error, rdata); end
        PREADY = '0; PRDATA = '0;
        tick();
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        PREADY = 4'b0000;
        request(1'b0, 32'h1000_3000, 32'h0);
        tick();
        transfer = 1'b0;
        tick();                           // ACCESS 1
        for (int i = 0; i < 15; i++) begin
            n_cmp++; if (ready !== 1'b0 || PENABLE !== 1'b1) begin
                n_err++; $display("FAIL to_wait_%0d: ready=%b PENABLE=%b want 0/1", i, ready, PENABLE); end
            tick();
        end                               // now in ACCESS 16
        tick();
        n_cmp++; if (ready !== 1'b1 || error !== 1'b1 || rdata !== 32'h0 || PSEL !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL to_abort: ready=%b error=%b rdata=%h PSEL=%b busy=%b want 1/1/0/0000/0", ready, error, rdata, PSEL, busy); end
        tick();
        set_rdata(3, 32'h0000_0F16);
        request(1'b0, 32'h1000_3000, 32'h0);
        tick();
        transfer = 1'b0;
        tick();                           // ACCESS 1
        for (int i = 0; i < 15; i++) tick();
        PREADY = 4'b1000;                 // ready on the 16th ACCESS cycle
        tick();
        n_cmp++; if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h0000_0F16) begin
            n_err++; $display("FAIL to_edge: ready=%b error=%b rdata=%h want 1/0/00000f16", ready, error, rdata); end
        PREADY = '0; PRDATA = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_decode_error();
        test_slverr_back_to_back();
        test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
